imem_loader: RTL and testbench

Writer side of the instruction memory. Accepts a big-endian byte stream over a valid/ready handshake, packs it into 32-bit instruction words, and writes them sequentially from word 0 into an internal instruction RAM. The fetch stage reads that RAM through a combinational port with the same byte-address indexing the CPU already uses. The loader holds the CPU until a program has been fully loaded.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_ram.sv | 41 ++++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings,
// the NOP word returned for out-of-range fetches and the default RAM depth.
package imem_loader_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // sll $0,$0,0 -- what the CPU executes when it fetches past the program
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int unsigned IMEM_DEPTH = 21;

    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction RAM: one synchronous write port from the loader and one
// combinational byte-addressed read port for the fetch stage.
module imem_loader_ram
    import imem_loader_pkg::*;
#(
    parameter int unsigned W = IMEM_DEPTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [addr_bits(W)-1:0]   waddr,
    input  logic [31:0]               wdata,
    input  logic [31:0]               addr,
    output logic [31:0]               rdata
);

    localparam int unsigned AW = addr_bits(W);
    localparam logic [29:0] DEPTH_WORDS = 30'(W);

    // Contents power up cleared on the FPGA and are deliberately not reset.
    logic [31:0] mem_q [W];

    logic [29:0] word_idx;
    logic        unused_addr_bits;

    assign word_idx         = addr[31:2];
    assign unused_addr_bits = ^addr[1:0];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = NOP_WORD;
        if (word_idx < DEPTH_WORDS) begin
            rdata = mem_q[word_idx[AW-1:0]];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into 32-bit words, writes them from word 0
// into the instruction RAM and holds the CPU until a load has completed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned W    = IMEM_DEPTH,
    parameter int unsigned LENW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LENW-1:0] len_words,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic            byte_ready,
    input  logic [31:0]     fetch_addr,
    output logic [31:0]     fetch_instr,
    output logic            cpu_hold,
    output logic            done,
    output logic            err,
    output logic [LENW-1:0] words_loaded
);

    localparam int unsigned AW = addr_bits(W);

    logic [1:0]      state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [LENW-1:0] word_idx_q, word_idx_d;
    logic [LENW-1:0] words_loaded_q, words_loaded_d;
    logic [LENW-1:0] len_q, len_d;
    logic            loaded_q, loaded_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            ram_we;
    logic [31:0]     ram_wdata;
    logic            accept;
    logic [LENW-1:0] words_next;

    assign byte_ready = (state_q == ST_LOAD);
    assign accept     = byte_valid && byte_ready;
    assign words_next = words_loaded_q + LENW'(1);

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        shift_d        = shift_q;
        word_idx_d     = word_idx_q;
        words_loaded_d = words_loaded_q;
        len_d          = len_q;
        loaded_d       = loaded_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        ram_we         = 1'b0;
        ram_wdata      = {shift_q, byte_in};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (32'(len_words) > W) begin
                        err_d = 1'b1;
                    end else if (len_words == '0) begin
                        state_d        = ST_DONE;
                        words_loaded_d = '0;
                        done_d         = 1'b1;
                        loaded_d       = 1'b1;
                    end else begin
                        state_d        = ST_LOAD;
                        len_d          = len_words;
                        byte_cnt_d     = 2'd0;
                        word_idx_d     = '0;
                        words_loaded_d = '0;
                        loaded_d       = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd3) begin
                        ram_we         = 1'b1;
                        byte_cnt_d     = 2'd0;
                        word_idx_d     = word_idx_q + LENW'(1);
                        words_loaded_d = words_next;
                        if (words_next == len_q) begin
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            loaded_d = 1'b1;
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], byte_in};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The partial word in shift_q is dropped on reset; RAM is left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= 2'd0;
            shift_q        <= '0;
            word_idx_q     <= '0;
            words_loaded_q <= '0;
            len_q          <= '0;
            loaded_q       <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            shift_q        <= shift_d;
            word_idx_q     <= word_idx_d;
            words_loaded_q <= words_loaded_d;
            len_q          <= len_d;
            loaded_q       <= loaded_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign cpu_hold     = ~loaded_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

    imem_loader_ram #(
        .W (W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_idx_q[AW-1:0]),
        .wdata (ram_wdata),
        .addr  (fetch_addr),
        .rdata (fetch_instr)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected done/err events and fetch results
// are queued by the stimulus and checked by independent monitors.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len_words = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] fetch_addr = '0;
    logic [31:0] fetch_instr;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        is_err;
        logic [15:0] wl;
        logic        hold;
    } ev_t;

    ev_t         evq[$];
    logic [31:0] fq[$];
    logic        rd_req = 1'b0;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len_words    (len_words),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Event monitor: every done/err pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (done || err) begin
            checks++;
            if (evq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=done:%0b/err:%0b required=none", done, err);
            end else begin
                ev_t e;
                e = evq.pop_front();
                if ({done, err} != (e.is_err ? 2'b01 : 2'b10) || words_loaded != e.wl ||
                    cpu_hold != e.hold) begin
                    failures++;
                    $display("FAIL event actual=done:%0b err:%0b wl:%0d hold:%0b required=err:%0b wl:%0d hold:%0b",
                             done, err, words_loaded, cpu_hold, e.is_err, e.wl, e.hold);
                end else begin
                    $display("EVENT %s wl=%0d hold=%0b", err ? "err" : "done", words_loaded, cpu_hold);
                end
            end
        end
    end

    // Fetch monitor: compares fetch_instr while a read request is presented.
    always @(negedge clk) begin
        if (rd_req) begin
            logic [31:0] exp_w;
            checks++;
            if (fq.size() == 0) begin
                failures++;
                $display("FAIL fetch_queue actual=empty required=entry");
            end else begin
                exp_w = fq.pop_front();
                if (fetch_instr !== exp_w) begin
                    failures++;
                    $display("FAIL fetch addr=%h actual=%h required=%h", fetch_addr, fetch_instr, exp_w);
                end else begin
                    $display("FETCH addr=%h data=%h", fetch_addr, fetch_instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] req);
        fetch_addr = addr;
        fq.push_back(req);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        len_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_in = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        chk("byte_ready_timeout", 32'(n >= 50), 32'd0);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] tmp;
            tmp = w << (8 * k);
            send_byte(tmp[31:24], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        end
    endtask

    function automatic logic [31:0] prog_word(input int i);
        case (i)
            0:       return 32'h8C10_0000;
            8:       return 32'h0800_000D;
            20:      return 32'h014B_702A;
            default: return 32'h2008_0000 | 32'(i);
        endcase
    endfunction

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words_loaded", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        tick();
        fetch(32'h0, 32'h0);

        // single word
        evq.push_back('{is_err: 1'b0, wl: 16'd1, hold: 1'b0});
        do_start(16'd1);
        chk("start_byte_ready", 32'(byte_ready), 32'd1);
        chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
        send_word(32'h8C10_0000, 0);
        chk("w1_done", 32'(done), 32'd1);
        chk("w1_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("w1_byte_ready", 32'(byte_ready), 32'd0);
        chk("w1_words_loaded", 32'(words_loaded), 32'd1);
        tick();
        chk("w1_done_pulse", 32'(done), 32'd0);
        fetch(32'h0, 32'h8C10_0000);

        // reset in the middle of the second word
        do_start(16'd2);
        chk("reload_cpu_hold", 32'(cpu_hold), 32'd1);
        send_word(32'h8C10_0000, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        tick();
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_words_loaded", 32'(words_loaded), 32'd0);
        chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
        rst = 1'b0;
        tick();
        fetch(32'h0, 32'h8C10_0000);
        fetch(32'h4, 32'h0);

        // restarted single-word load
        evq.push_back('{is_err: 1'b0, wl: 16'd1, hold: 1'b0});
        do_start(16'd1);
        send_word(32'h1234_5678, 0);
        chk("restart_done", 32'(done), 32'd1);
        tick();
        fetch(32'h0, 32'h1234_5678);
        fetch(32'h4, 32'h0);

        // full 21-word program with gaps; start mid-load must be ignored
        evq.push_back('{is_err: 1'b0, wl: 16'd21, hold: 1'b0});
        do_start(16'd21);
        for (int i = 0; i < 21; i++) begin
            send_word(prog_word(i), 2);
            if (i == 5) begin
                start = 1'b1;
                len_words = 16'd3;
                tick();
                start = 1'b0;
                chk("ignored_start_ready", 32'(byte_ready), 32'd1);
            end
            if (i < 20) chk("full_no_done", 32'(done), 32'd0);
        end
        chk("full_done", 32'(done), 32'd1);
        chk("full_words_loaded", 32'(words_loaded), 32'd21);
        chk("full_cpu_hold", 32'(cpu_hold), 32'd0);
        byte_in = 8'hFF;
        byte_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("post_done_ready", 32'(byte_ready), 32'd0);
            tick();
        end
        byte_valid = 1'b0;
        chk("post_done_words", 32'(words_loaded), 32'd21);
        fetch(32'h00, 32'h8C10_0000);
        fetch(32'h20, 32'h0800_000D);
        fetch(32'h50, 32'h014B_702A);
        fetch(32'h54, 32'h0);
        fetch(32'h03, 32'h8C10_0000);
        for (int i = 0; i < 21; i++) fetch(32'(i * 4), prog_word(i));

        // length errors
        evq.push_back('{is_err: 1'b1, wl: 16'd21, hold: 1'b0});
        do_start(16'd22);
        chk("len22_err", 32'(err), 32'd1);
        chk("len22_byte_ready", 32'(byte_ready), 32'd0);
        tick();
        chk("len22_err_pulse", 32'(err), 32'd0);
        chk("len22_byte_ready2", 32'(byte_ready), 32'd0);
        fetch(32'h50, 32'h014B_702A);

        evq.push_back('{is_err: 1'b0, wl: 16'd0, hold: 1'b0});
        do_start(16'd0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_byte_ready", 32'(byte_ready), 32'd0);
        chk("len0_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (3) tick();

        chk("events_drained", 32'(evq.size()), 32'd0);
        chk("fetches_drained", 32'(fq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
